// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB packet transmitter.
// CRC16 constants are used only when USB_TX_CRC16_EN is defined.
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        EOP
    } tx_state_t;

    // Line state packed as {D+, D-}
    typedef logic [1:0] line_t;

    localparam line_t J   = 2'b10;
    localparam line_t K   = 2'b01;
    localparam line_t SE0 = 2'b00;

    localparam logic [7:0]  SYNC_PATTERN = 8'h80;
    localparam logic [15:0] CRC16_POLY   = 16'h8005;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

    // NRZI: a 0 toggles J<->K, a 1 holds the line
    function automatic line_t nrzi(input line_t cur, input logic b);
        if (b) begin
            return cur;
        end
        return (cur == K) ? J : K;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: byte-wide USB CRC16, LSB-first (reflected) form, inverted output.
// Instantiated by usb_transmitter only when USB_TX_CRC16_EN is defined.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    localparam logic [15:0] POLY_REFL = rev16(CRC16_POLY);

    logic [15:0] r_crc;
    logic [15:0] w_crc_nxt;

    always_comb begin
        w_crc_nxt = r_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_crc_nxt[0] ^ i_data[i]) begin
                w_crc_nxt = (w_crc_nxt >> 1) ^ POLY_REFL;
            end else begin
                w_crc_nxt = w_crc_nxt >> 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= CRC16_INIT;
        end else if (i_init) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= w_crc_nxt;
        end
    end

    assign o_crc = ~r_crc;

endmodule

// File: rtl/usb_transmitter.sv
// usb_transmitter: USB packet serializer with SYNC, NRZI, bit stuffing and EOP.
// Define USB_TX_CRC16_EN to append a CRC16 over all bytes after the PID.
module usb_transmitter
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_data_ready,
    output logic       d_plus_out,
    output logic       d_minus_out,
    output logic       transmitting,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t     r_state;
    tx_state_t     w_next;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_data;
    logic [3:0]    r_idx;
    logic [2:0]    r_ones;
    logic          r_last;
    line_t         r_line;
    logic          r_tx;
    logic          r_done;
    logic          r_err;

    logic          w_bit_end;
    logic          w_stuff;
    logic          w_byte_end;
    logic          w_ready_cyc;
    logic          w_take;
    logic          w_underrun;
    logic          w_to_crc;
    logic          w_eop_end;
    logic          w_tx_bit;
    logic          w_crc_bit;
    logic [3:0]    w_idx_inc;
    logic [3:0]    w_last_idx;
    logic [2:0]    w_ones_nxt;
    line_t         w_line_nxt;

`ifdef USB_TX_CRC16_EN
    logic        r_crc_phase;
    logic [15:0] w_crc;
    logic        w_crc_init;

    assign w_crc_init = (r_state == IDLE);

    usb_crc16 u_crc (
        .clk    (clk),
        .rst    (rst),
        .i_init (w_crc_init),
        .i_en   (w_take),
        .i_data (tx_data),
        .o_crc  (w_crc)
    );

    assign w_crc_bit  = w_crc[0];
    assign w_last_idx = r_crc_phase ? 4'd15 : 4'd7;
    assign w_to_crc   = w_byte_end && r_last && !r_crc_phase;
`else
    assign w_crc_bit  = 1'b0;
    assign w_last_idx = 4'd7;
    assign w_to_crc   = 1'b0;
`endif

    assign w_bit_end   = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_stuff     = (r_ones == 3'd6);
    assign w_idx_inc   = r_idx + 4'd1;
    // A pending stuff bit belongs to the byte, so it delays the byte end
    assign w_byte_end  = (r_state == DATA) && w_bit_end && !w_stuff
                         && (r_idx == w_last_idx);
    assign w_ready_cyc = w_byte_end && !r_last;
    assign w_take      = w_ready_cyc && tx_data_valid;
    assign w_underrun  = w_ready_cyc && !tx_data_valid;
    assign w_eop_end   = (r_state == EOP) && w_bit_end && (r_idx == 4'd2);

    // Next bit to put on the wire at the coming bit boundary
    always_comb begin
        w_tx_bit = 1'b0;
        unique case (r_state)
            IDLE: w_tx_bit = SYNC_PATTERN[0];
            SYNC: begin
                if (r_idx == 4'd7) begin
                    w_tx_bit = r_data[0];
                end else begin
                    w_tx_bit = SYNC_PATTERN[w_idx_inc[2:0]];
                end
            end
            DATA: begin
                if (w_stuff) begin
                    w_tx_bit = 1'b0;
                end else if (r_idx != w_last_idx) begin
                    w_tx_bit = r_data[w_idx_inc];
                end else if (w_take) begin
                    w_tx_bit = tx_data[0];
                end else begin
                    w_tx_bit = w_crc_bit;
                end
            end
            default: w_tx_bit = 1'b0;
        endcase
    end

    assign w_line_nxt = nrzi(r_line, w_tx_bit);
    assign w_ones_nxt = w_tx_bit ? (r_ones + 3'd1) : 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (tx_data_valid) w_next = SYNC;
            SYNC: if (w_bit_end && (r_idx == 4'd7)) w_next = DATA;
            DATA: if (w_byte_end && !w_take && !w_to_crc) w_next = EOP;
            EOP:  if (w_eop_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        tx_data_ready = 1'b0;
        if (!rst) begin
            tx_data_ready = (r_state == IDLE) || w_ready_cyc;
        end
        d_plus_out   = r_line[1];
        d_minus_out  = r_line[0];
        transmitting = r_tx;
        tx_done      = r_done;
        tx_error     = r_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_idx  <= '0;
            r_ones <= '0;
            r_last <= 1'b0;
            r_line <= J;
            r_tx   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
`ifdef USB_TX_CRC16_EN
            r_crc_phase <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= (r_state == IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (tx_data_valid) begin
                        r_data <= {8'h00, tx_data};
                        r_last <= tx_last;
                        r_idx  <= '0;
                        r_tx   <= 1'b1;
                        r_line <= w_line_nxt;
                        r_ones <= w_ones_nxt;
`ifdef USB_TX_CRC16_EN
                        r_crc_phase <= 1'b0;
`endif
                    end
                end
                SYNC: begin
                    if (w_bit_end) begin
                        r_line <= w_line_nxt;
                        r_ones <= w_ones_nxt;
                        r_idx  <= (r_idx == 4'd7) ? 4'd0 : w_idx_inc;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (w_stuff || (r_idx != w_last_idx)) begin
                            r_line <= w_line_nxt;
                            r_ones <= w_ones_nxt;
                            if (!w_stuff) begin
                                r_idx <= w_idx_inc;
                            end
                        end else if (w_take) begin
                            r_data <= {8'h00, tx_data};
                            r_last <= tx_last;
                            r_idx  <= '0;
                            r_line <= w_line_nxt;
                            r_ones <= w_ones_nxt;
                        end else if (w_to_crc) begin
`ifdef USB_TX_CRC16_EN
                            r_data      <= w_crc;
                            r_crc_phase <= 1'b1;
`endif
                            r_idx  <= '0;
                            r_line <= w_line_nxt;
                            r_ones <= w_ones_nxt;
                        end else begin
                            r_line <= SE0;
                            r_idx  <= '0;
                            r_ones <= '0;
                            r_err  <= w_underrun;
                        end
                    end
                end
                EOP: begin
                    if (w_bit_end) begin
                        if (r_idx == 4'd2) begin
                            r_idx  <= '0;
                            r_tx   <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_idx <= w_idx_inc;
                            if (r_idx == 4'd1) begin
                                r_line <= J;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
